// File: rtl/plot_arbiter.sv
// plot_arbiter: burst-granting arbiter that shares the registered pixel-write port between snake and overlay.
// Define PLOT_ARB_TIMEOUT_EN to enable forced release of an owner that stays idle for TIMEOUT cycles.
module plot_arbiter #(
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          snk_valid,
    input  logic          snk_last,
    input  logic [XW-1:0] snk_x,
    input  logic [YW-1:0] snk_y,
    input  logic [CW-1:0] snk_colour,
    output logic          snk_ready,
    input  logic          ovl_valid,
    input  logic          ovl_last,
    input  logic [XW-1:0] ovl_x,
    input  logic [YW-1:0] ovl_y,
    input  logic [CW-1:0] ovl_colour,
    output logic          ovl_ready,
    input  logic          prio_ovl,
    output logic          plot,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [CW-1:0] colour_out,
    output logic [1:0]    owner,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_SNK = 2'b01,
        GNT_OVL = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   last_ovl;
    logic   snk_acc, ovl_acc;
    logic   force_rel;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("plot_arbiter: TIMEOUT must be at least 1");
    end

    assign snk_ready = (state == GNT_SNK);
    assign ovl_ready = (state == GNT_OVL);
    assign owner     = state;
    assign snk_acc   = snk_ready & snk_valid;
    assign ovl_acc   = ovl_ready & ovl_valid;

`ifdef PLOT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;
    logic          owner_valid;

    assign owner_valid = snk_acc | ovl_acc;
    // Release fires on the edge where the count of consecutive idle owner cycles reaches TIMEOUT.
    assign force_rel   = (state != IDLE) && !owner_valid && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (state == IDLE || owner_valid || force_rel)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // NOTE: next state gets its default first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (snk_valid && ovl_valid)
                    state_nxt = (prio_ovl || !last_ovl) ? GNT_OVL : GNT_SNK;
                else if (snk_valid)
                    state_nxt = GNT_SNK;
                else if (ovl_valid)
                    state_nxt = GNT_OVL;
            end
            GNT_SNK: if ((snk_acc && snk_last) || force_rel) state_nxt = IDLE;
            GNT_OVL: if ((ovl_acc && ovl_last) || force_rel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state and output registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_ovl   <= 1'b1;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE)
                last_ovl <= (state_nxt == GNT_OVL);
            plot <= snk_acc | ovl_acc;
            if (snk_acc) begin
                x_out      <= snk_x;
                y_out      <= snk_y;
                colour_out <= snk_colour;
            end else if (ovl_acc) begin
                x_out      <= ovl_x;
                y_out      <= ovl_y;
                colour_out <= ovl_colour;
            end
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: per-cycle comparison against a burst-level model plus directed literal checks.
// Timeout expectations follow PLOT_ARB_TIMEOUT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_plot_arbiter;

    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int CW    = 3;
    localparam int TO    = 4;
    localparam int SNK_C = 2;
    localparam int OVL_C = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          snk_valid = 1'b0, snk_last = 1'b0;
    logic [XW-1:0] snk_x = '0;
    logic [YW-1:0] snk_y = '0;
    logic [CW-1:0] snk_colour = '0;
    logic          snk_ready;
    logic          ovl_valid = 1'b0, ovl_last = 1'b0;
    logic [XW-1:0] ovl_x = '0;
    logic [YW-1:0] ovl_y = '0;
    logic [CW-1:0] ovl_colour = '0;
    logic          ovl_ready;
    logic          prio_ovl = 1'b0;
    logic          plot;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [CW-1:0] colour_out;
    logic [1:0]    owner;
    logic          timeout;

    always #5 clk = ~clk;

    plot_arbiter #(.XW(XW), .YW(YW), .CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .snk_valid(snk_valid), .snk_last(snk_last), .snk_x(snk_x), .snk_y(snk_y),
        .snk_colour(snk_colour), .snk_ready(snk_ready),
        .ovl_valid(ovl_valid), .ovl_last(ovl_last), .ovl_x(ovl_x), .ovl_y(ovl_y),
        .ovl_colour(ovl_colour), .ovl_ready(ovl_ready),
        .prio_ovl(prio_ovl), .plot(plot), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .owner(owner), .timeout(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit abort_s = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at t=%0t: wait bound expired", name, $time);
    endtask

    // Model: who holds the port, who won last, and what the port must show.
    int            m_holder, m_prev, m_idle, m_win;
    logic          m_plot, m_to;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    logic [CW-1:0] m_c;
    logic          m_s_acc, m_o_acc, m_hold_valid, m_cur_last, m_expire;

    function automatic int pick(input logic sv, input logic ov, input logic po, input int prev);
        if (sv && ov) return po ? 2 : ((prev == 1) ? 2 : 1);
        if (sv) return 1;
        if (ov) return 2;
        return 0;
    endfunction

    always_comb begin
        m_s_acc      = (m_holder == 1) && snk_valid;
        m_o_acc      = (m_holder == 2) && ovl_valid;
        m_hold_valid = m_s_acc || m_o_acc;
        m_cur_last   = (m_holder == 1) ? snk_last : ovl_last;
        m_win        = (m_holder == 0) ? pick(snk_valid, ovl_valid, prio_ovl, m_prev) : 0;
        m_expire     = 1'b0;
`ifdef PLOT_ARB_TIMEOUT_EN
        if (m_holder != 0 && !m_hold_valid && (m_idle + 1 >= TO)) m_expire = 1'b1;
`endif
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_holder <= 0;
            m_prev   <= 2;
            m_idle   <= 0;
            m_plot   <= 1'b0;
            m_to     <= 1'b0;
            m_x      <= '0;
            m_y      <= '0;
            m_c      <= '0;
        end else begin
            m_plot <= m_s_acc || m_o_acc;
            if (m_s_acc) begin
                m_x <= snk_x; m_y <= snk_y; m_c <= snk_colour;
            end else if (m_o_acc) begin
                m_x <= ovl_x; m_y <= ovl_y; m_c <= ovl_colour;
            end
            m_to   <= m_expire;
            m_idle <= (m_holder == 0 || m_hold_valid || m_expire) ? 0 : m_idle + 1;
            if (m_holder == 0) begin
                if (m_win != 0) begin
                    m_holder <= m_win;
                    m_prev   <= m_win;
                end
            end else if ((m_hold_valid && m_cur_last) || m_expire) begin
                m_holder <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("plot",       int'(plot),       int'(m_plot));
            check("x_out",      int'(x_out),      int'(m_x));
            check("y_out",      int'(y_out),      int'(m_y));
            check("colour_out", int'(colour_out), int'(m_c));
            check("owner",      int'(owner),      m_holder);
            check("snk_ready",  int'(snk_ready),  int'(m_holder == 1));
            check("ovl_ready",  int'(ovl_ready),  int'(m_holder == 2));
            check("timeout",    int'(timeout),    int'(m_to));
        end
    end

    // Logs for the directed literal checks.
    int grants[$];
    int plot_cyc[$];
    int plot_x[$];
    int plot_src[$];
    int to_cnt   = 0;
    int prev_own = 0;

    always @(negedge clk) begin
        if (plot) begin
            plot_cyc.push_back(cyc);
            plot_x.push_back(int'(x_out));
            plot_src.push_back((int'(colour_out) == SNK_C) ? 1 : 2);
        end
        if (int'(owner) != prev_own && owner != 2'b00) grants.push_back(int'(owner));
        prev_own <= int'(owner);
        if (timeout) to_cnt <= to_cnt + 1;
    end

    task automatic snk_pix(input int x, input int y, input int c, input bit last);
        int budget = 0;
        bit acc    = 1'b0;
        snk_valid  = 1'b1;
        snk_x      = XW'(x);
        snk_y      = YW'(y);
        snk_colour = CW'(c);
        snk_last   = last;
        while (!acc && !abort_s && budget < 500) begin
            @(negedge clk);
            acc = snk_ready && !rst;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc && !abort_s) bound_fail("snk_handshake");
    endtask

    task automatic ovl_pix(input int x, input int y, input int c, input bit last);
        int budget = 0;
        bit acc    = 1'b0;
        ovl_valid  = 1'b1;
        ovl_x      = XW'(x);
        ovl_y      = YW'(y);
        ovl_colour = CW'(c);
        ovl_last   = last;
        while (!acc && budget < 500) begin
            @(negedge clk);
            acc = ovl_ready && !rst;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) bound_fail("ovl_handshake");
    endtask

    task automatic snk_burst(input int n, input int x0, input int y, input int c);
        for (int i = 0; i < n; i++) snk_pix(x0 + i, y, c, i == n - 1);
        snk_valid = 1'b0;
        snk_last  = 1'b0;
    endtask

    task automatic ovl_burst(input int n, input int x0, input int y, input int c);
        for (int i = 0; i < n; i++) ovl_pix(x0 + i, y, c, i == n - 1);
        ovl_valid = 1'b0;
        ovl_last  = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb, pb, t0, last_o, first_s, early_s, n_o, tb0;
        bit seen;

        // Reset state.
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_plot",   int'(plot), 0);
        check("rst_x",      int'(x_out), 0);
        check("rst_y",      int'(y_out), 0);
        check("rst_colour", int'(colour_out), 0);
        check("rst_owner",  int'(owner), 0);
        check("rst_ready",  int'({snk_ready, ovl_ready}), 0);
        check("rst_to",     int'(timeout), 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Snake-only 4-pixel burst.
        pb = plot_x.size();
        t0 = cyc;
        snk_burst(4, 10, 5, SNK_C);
        check("t1_owner_after", int'(owner), 0);
        repeat (2) @(posedge clk);
        #1;
        check("t1_nplots", plot_x.size() - pb, 4);
        if (plot_x.size() - pb == 4) begin
            check("t1_latency", plot_cyc[pb] - t0, 2);
            check("t1_back2back", plot_cyc[pb + 3] - plot_cyc[pb], 3);
            for (int i = 0; i < 4; i++) check("t1_x", plot_x[pb + i], 10 + i);
        end

        // Round-robin tie from reset: snake, overlay, snake.
        do_reset();
        gb = grants.size();
        pb = plot_x.size();
        fork
            begin
                snk_burst(2, 30, 1, SNK_C);
                snk_burst(2, 40, 1, SNK_C);
            end
            ovl_burst(2, 50, 2, OVL_C);
        join
        repeat (2) @(posedge clk);
        #1;
        check("t2_ngrants", grants.size() - gb, 3);
        if (grants.size() - gb == 3) begin
            check("t2_g0", grants[gb], 1);
            check("t2_g1", grants[gb + 1], 2);
            check("t2_g2", grants[gb + 2], 1);
        end
        check("t2_nplots", plot_x.size() - pb, 6);
        if (plot_x.size() - pb == 6) begin
            check("t2_bubble_a", plot_cyc[pb + 2] - plot_cyc[pb + 1], 2);
            check("t2_bubble_b", plot_cyc[pb + 4] - plot_cyc[pb + 3], 2);
            check("t2_x2", plot_x[pb + 2], 50);
        end

        // Overlay priority wins every tie.
        prio_ovl = 1'b1;
        gb = grants.size();
        fork
            snk_burst(2, 60, 3, SNK_C);
            begin
                ovl_burst(2, 70, 3, OVL_C);
                ovl_burst(2, 72, 3, OVL_C);
            end
        join
        prio_ovl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t3_ngrants", grants.size() - gb, 3);
        if (grants.size() - gb == 3) begin
            check("t3_g0", grants[gb], 2);
            check("t3_g1", grants[gb + 1], 2);
            check("t3_g2", grants[gb + 2], 1);
        end

        // Long overlay burst is never interleaved.
        pb = plot_x.size();
        fork
            ovl_burst(160, 0, 10, OVL_C);
            begin
                repeat (5) @(posedge clk);
                #1;
                snk_burst(1, 99, 10, SNK_C);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        last_o = -1; first_s = -1; early_s = 0; n_o = 0;
        for (int i = pb; i < plot_x.size(); i++) begin
            if (plot_src[i] == 2) begin
                last_o = plot_cyc[i];
                n_o++;
            end else if (first_s < 0) begin
                first_s = plot_cyc[i];
            end
        end
        for (int i = pb; i < plot_x.size(); i++)
            if (plot_src[i] == 1 && plot_cyc[i] < last_o) early_s++;
        check("t4_novl", n_o, 160);
        check("t4_interleave", early_s, 0);
        check("t4_handover", first_s - last_o, 2);

        // Asynchronous reset while pixel 3 of 5 is on offer.
        gb = grants.size();
        fork
            snk_burst(5, 20, 4, SNK_C);
            begin
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (plot && x_out == XW'(21)) seen = 1'b1;
                end
                if (!seen) bound_fail("t5_wait_pixel2");
                #2 rst = 1'b1;
                #1;
                check("t5_plot",   int'(plot), 0);
                check("t5_x",      int'(x_out), 0);
                check("t5_y",      int'(y_out), 0);
                check("t5_colour", int'(colour_out), 0);
                check("t5_owner",  int'(owner), 0);
                abort_s = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        abort_s = 1'b0;
        @(posedge clk);
        #1;
        gb = grants.size();
        fork
            snk_burst(1, 33, 4, SNK_C);
            ovl_burst(1, 44, 4, OVL_C);
        join
        repeat (2) @(posedge clk);
        #1;
        check("t5_ngrants", grants.size() - gb, 2);
        if (grants.size() - gb == 2) check("t5_first", grants[gb], 1);

        // Owner goes idle for TIMEOUT cycles while the overlay waits.
        gb  = grants.size();
        pb  = plot_x.size();
        tb0 = to_cnt;
        fork
            begin
                snk_pix(80, 6, SNK_C, 1'b0);
                snk_valid = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                snk_pix(81, 6, SNK_C, 1'b1);
                snk_valid = 1'b0;
                snk_last  = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                ovl_pix(90, 6, OVL_C, 1'b1);
                ovl_valid = 1'b0;
                ovl_last  = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("t6_nplots", plot_x.size() - pb, 3);
`ifdef PLOT_ARB_TIMEOUT_EN
        check("t6_pulses", to_cnt - tb0, 1);
        check("t6_ngrants", grants.size() - gb, 3);
        if (plot_x.size() - pb == 3) begin
            check("t6_x1", plot_x[pb + 1], 90);
            check("t6_x2", plot_x[pb + 2], 81);
        end
`else
        check("t6_pulses", to_cnt - tb0, 0);
        check("t6_ngrants", grants.size() - gb, 2);
        if (plot_x.size() - pb == 3) begin
            check("t6_x1", plot_x[pb + 1], 81);
            check("t6_x2", plot_x[pb + 2], 90);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single pixel-write port (plot, x, y, colour) between the snake datapath and the overlay drawer (title, game-over and black-fill screens). The arbiter grants the port per burst with a valid/ready handshake. It registers the winning pixel onto the output port and guarantees that pixels from the two requesters never interleave within a burst. It replaces the combinational OR/priority mux at the top of the game interface.

## Interface
Parameters:
- XW, 8: x coordinate width
- YW, 7: y coordinate width
- CW, 3: colour width
- TIMEOUT, 255: idle-owner cycles before forced release (used only with the macro); must be ≥1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- snk_valid  in  1  snake pixel valid
- snk_last  in  1  final pixel of snake burst
- snk_x / snk_y / snk_colour  in  XW/YW/CW  snake pixel
- snk_ready  out  1  snake pixel accepted this cycle when valid
- ovl_valid, ovl_last, ovl_x, ovl_y, ovl_colour, ovl_ready: same as the snake set, for the overlay requester
- prio_ovl  in  1  1 = overlay wins every tie; 0 = round-robin
- plot  out  1  pixel write strobe
- x_out / y_out / colour_out  out  XW/YW/CW  registered pixel
- owner  out  2  00 none, 01 snake, 10 overlay (current state)
- timeout  out  1  one-cycle pulse on forced release

## Operation
- States are IDLE, GNT_SNK and GNT_OVL.
- In IDLE:
  - If no valid is asserted, stay in IDLE.
  - If only one valid is asserted, go to that requester's grant state.
  - If both are asserted and prio_ovl=1, go to GNT_OVL.
  - If both are asserted and prio_ovl=0, go to the requester other than last_owner.
  - last_owner updates on entry to a grant state.
- Ready signals:
  - snk_ready = (state==GNT_SNK); ovl_ready = (state==GNT_OVL). Both are combinational from state.
  - The arbiter never asserts ready in IDLE.
- A pixel is accepted when valid & ready.
  - On acceptance, x_out, y_out and colour_out load the pixel at the next edge, and plot=1 for exactly that cycle.
  - With no acceptance, plot=0 and x_out, y_out and colour_out hold their value.
- An accepted pixel with last=1 ends the burst and the state returns to IDLE at the same edge. The non-owner's valid is ignored until then.
- The owner may drop valid mid-burst; it keeps the grant and acceptance resumes when valid returns.
- A requester's valid may be held across IDLE; its data must stay stable while valid is high and ready is low.
- A 1-pixel burst (valid & last on the first granted cycle) is legal.
- owner reflects the state: 01/10 in a grant state, 00 in IDLE.

## Timing
- Reset (async, any time including mid-burst):
  - state = IDLE, last_owner = overlay (so the snake wins the first round-robin tie).
  - plot = 0; x_out, y_out, colour_out = 0; timeout = 0; timeout counter = 0.
- Latency:
  - valid rising in IDLE → ready high 1 cycle later → plot high 1 cycle after acceptance.
  - Minimum request-to-plot latency is 2 cycles.
- Throughput:
  - One pixel per cycle inside a burst.
  - There is exactly one IDLE bubble cycle between consecutive bursts, including same-owner back-to-back bursts.
- prio_ovl is sampled only in IDLE; changing it mid-burst has no effect on the current owner.

## Configuration
- `PLOT_ARB_TIMEOUT_EN` defined:
  - In a grant state, a counter increments each cycle the owner's valid is low and clears on any owner valid.
  - When the counter reaches TIMEOUT, the state forces to IDLE at the next edge, timeout pulses for one cycle, and the counter clears.
  - Round-robin then serves the other requester if it is waiting.
- `PLOT_ARB_TIMEOUT_EN` undefined:
  - No counter exists and timeout is tied to 0.
  - The owner holds the grant indefinitely until it delivers last.

## Test plan
- Snake-only burst: snk_valid=1 for 4 pixels (x=10..13, y=5, colour=3'b010) with last on the 4th → snk_ready high 1 cycle after valid; plot high on 4 consecutive cycles starting 2 cycles after valid; x_out=10,11,12,13; owner returns to 00.
- Tie, round-robin (prio_ovl=0), both valid from reset, 2-pixel bursts each → snake served first; one IDLE bubble; overlay served next; then snake again.
- Tie with prio_ovl=1, both valid repeatedly → overlay wins every arbitration; snake is served only when ovl_valid=0 in IDLE.
- Non-interleave: overlay burst of 160 pixels in progress while snk_valid rises → snk_ready stays 0 and no snake pixel appears until 1 cycle after the overlay's last pixel is accepted.
- Mid-burst reset: assert rst during pixel 3 of a 5-pixel burst → plot=0, x_out/y_out/colour_out=0, owner=00 immediately; after release, a tie goes to the snake.
- Timeout (macro defined, TIMEOUT=4): snake owner drops valid for 4 cycles mid-burst with ovl_valid=1 → timeout pulses once; overlay granted on the next arbitration. With the macro undefined, the same stimulus keeps owner=01 and timeout=0.
